// File: rtl/smc_sram_arb.sv
// smc_sram_arb: shares one single-port 32-bit SRAM macro between NPORT
// AHB-Lite slave ports. Each port captures its address phase into a pending
// slot and holds hready low until a round-robin arbiter has served it; the
// arbiter issues at most one SRAM access per cycle.
// Build option: define SMC_ARB_PRIO_EN to give port 0 absolute priority,
// with ports 1..NPORT-1 round-robin among themselves.
module smc_sram_arb #(
  parameter int NPORT = 3,
  parameter int AW    = 14
) (
  input  logic                pmu_smc_hclk,
  input  logic                pmu_smc_hrst_b,
  input  logic [NPORT-1:0]    hmain0_smc_hsel,
  input  logic [NPORT*32-1:0] hmain0_smc_haddr,
  input  logic [NPORT*2-1:0]  hmain0_smc_htrans,
  input  logic [NPORT-1:0]    hmain0_smc_hwrite,
  input  logic [NPORT*3-1:0]  hmain0_smc_hsize,
  input  logic [NPORT*32-1:0] hmain0_smc_hwdata,
  output logic [NPORT*32-1:0] smc_hmain0_hrdata,
  output logic [NPORT-1:0]    smc_hmain0_hready,
  output logic [NPORT*2-1:0]  smc_hmain0_hresp,
  output logic                sram_cen,
  output logic [3:0]          sram_wen,
  output logic [AW-1:0]       sram_addr,
  output logic [31:0]         sram_wdata,
  input  logic [31:0]         sram_rdata
);

  // Pointer width covers NPORT = 2..4.
  localparam int PW = (NPORT > 2) ? 2 : 1;

  typedef enum logic [1:0] {P_IDLE, P_PEND, P_ERR1, P_ERR2} port_state_e;

  port_state_e      state_q     [NPORT];
  port_state_e      state_d     [NPORT];
  logic [AW+1:0]    slot_addr_q [NPORT];
  logic [1:0]       slot_size_q [NPORT];
  logic [NPORT-1:0] slot_write_q;
  logic [NPORT-1:0] done_q;    // port was granted last cycle: this is its completion cycle
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    ptr_d;
  logic [NPORT-1:0] capture;
  logic [NPORT-1:0] size_err;
  logic [NPORT-1:0] req;
  logic [NPORT-1:0] gnt;
  logic             gnt_vld;
  int               cand;
  logic [NPORT-1:0] unused_bits;

  // Byte lanes touched by an access of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      2'd0:    lane_mask = 4'b0001 << ofs;
      2'd1:    lane_mask = ofs[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  for (genvar i = 0; i < NPORT; i++) begin : g_port
    assign capture[i]  = hmain0_smc_hsel[i] & hmain0_smc_htrans[2*i+1] & smc_hmain0_hready[i];
    assign size_err[i] = hmain0_smc_hsize[3*i +: 3] > 3'd2;
    assign req[i]      = (state_q[i] == P_PEND) & ~done_q[i];
    // Upper address bits and htrans[0] (SEQ vs NONSEQ) carry no meaning here.
    assign unused_bits[i] = ^{hmain0_smc_haddr[32*i+31 : 32*i+AW+2], hmain0_smc_htrans[2*i]};
  end

  // Per-port next state: a capture always wins, otherwise error and completion states retire.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      state_d[i] = state_q[i];
      if (capture[i]) begin
        state_d[i] = size_err[i] ? P_ERR1 : P_PEND;
      end else begin
        case (state_q[i])
          P_ERR1:  state_d[i] = P_ERR2;
          P_ERR2:  state_d[i] = P_IDLE;
          P_PEND:  if (done_q[i]) state_d[i] = P_IDLE;
          default: state_d[i] = state_q[i];
        endcase
      end
    end
  end

  // Per-port AHB response: wait states while pending or in the first error cycle.
  always_comb begin
    smc_hmain0_hready = '1;
    smc_hmain0_hresp  = '0;
    smc_hmain0_hrdata = '0;
    for (int i = 0; i < NPORT; i++) begin
      case (state_q[i])
        P_PEND: smc_hmain0_hready[i] = done_q[i];
        P_ERR1: begin
          smc_hmain0_hready[i]       = 1'b0;
          smc_hmain0_hresp[2*i +: 2] = 2'b01;
        end
        P_ERR2: smc_hmain0_hresp[2*i +: 2] = 2'b01;
        default: ;
      endcase
      // SRAM read data is only meaningful on the owner's completion cycle.
      if (done_q[i] & ~slot_write_q[i]) smc_hmain0_hrdata[32*i +: 32] = sram_rdata;
    end
  end

  // Arbiter: first requester after the pointer wins (port 0 first in the priority build).
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    ptr_d   = ptr_q;
    cand    = 0;
`ifdef SMC_ARB_PRIO_EN
    // Port 0 bypasses the round robin and leaves the pointer alone.
    if (req[0]) begin
      gnt[0]  = 1'b1;
      gnt_vld = 1'b1;
    end
`endif
    for (int k = 1; k <= NPORT; k++) begin
      cand = (int'(ptr_q) + k) % NPORT;
      if (!gnt_vld && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_vld   = 1'b1;
        ptr_d     = PW'(cand);
      end
    end
  end

  // SRAM command for the granted port; idle values otherwise.
  always_comb begin
    sram_cen   = 1'b1;
    sram_wen   = 4'hF;
    sram_addr  = '0;
    sram_wdata = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (gnt[i]) begin
        sram_cen  = 1'b0;
        sram_addr = slot_addr_q[i][AW+1:2];
        if (slot_write_q[i]) begin
          sram_wen   = ~lane_mask(slot_size_q[i], slot_addr_q[i][1:0]);
          // Grant is at least one cycle after capture, so hwdata is in its data phase.
          sram_wdata = hmain0_smc_hwdata[32*i +: 32];
        end
      end
    end
  end

  // Port states, completion flags and round-robin pointer.
  always_ff @(posedge pmu_smc_hclk or negedge pmu_smc_hrst_b) begin
    if (!pmu_smc_hrst_b) begin
      for (int i = 0; i < NPORT; i++) state_q[i] <= P_IDLE;
      done_q <= '0;
      ptr_q  <= PW'(NPORT - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < NPORT; i++) state_q[i] <= state_d[i];
      done_q <= gnt;
      ptr_q  <= ptr_d;
    end
  end

  // Pending slots load on each capture.
  always_ff @(posedge pmu_smc_hclk or negedge pmu_smc_hrst_b) begin
    if (!pmu_smc_hrst_b) begin
      // NOTE: the slots are a handful of flops, not a RAM, so clearing them on reset is cheap and keeps stale accesses out.
      for (int i = 0; i < NPORT; i++) begin
        slot_addr_q[i] <= '0;
        slot_size_q[i] <= '0;
      end
      slot_write_q <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (capture[i]) begin
          slot_addr_q[i]  <= hmain0_smc_haddr[32*i +: AW+2];
          slot_size_q[i]  <= hmain0_smc_hsize[3*i +: 2];
          slot_write_q[i] <= hmain0_smc_hwrite[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_smc_sram_arb.sv
// tb_smc_sram_arb: directed bench for smc_sram_arb with a behavioural SRAM.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_smc_sram_arb;
  localparam int NPORT = 3;
  localparam int AW    = 14;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NPORT-1:0]    hsel;
  logic [NPORT*32-1:0] haddr;
  logic [NPORT*2-1:0]  htrans;
  logic [NPORT-1:0]    hwrite;
  logic [NPORT*3-1:0]  hsize;
  logic [NPORT*32-1:0] hwdata;
  logic [NPORT*32-1:0] hrdata;
  logic [NPORT-1:0]    hready;
  logic [NPORT*2-1:0]  hresp;
  logic                sram_cen;
  logic [3:0]          sram_wen;
  logic [AW-1:0]       sram_addr;
  logic [31:0]         sram_wdata;
  logic [31:0]         sram_rdata;
  logic [31:0]         mem [0:(1<<AW)-1];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  smc_sram_arb #(.NPORT(NPORT), .AW(AW)) dut (
    .pmu_smc_hclk      (clk),
    .pmu_smc_hrst_b    (rst_n),
    .hmain0_smc_hsel   (hsel),
    .hmain0_smc_haddr  (haddr),
    .hmain0_smc_htrans (htrans),
    .hmain0_smc_hwrite (hwrite),
    .hmain0_smc_hsize  (hsize),
    .hmain0_smc_hwdata (hwdata),
    .smc_hmain0_hrdata (hrdata),
    .smc_hmain0_hready (hready),
    .smc_hmain0_hresp  (hresp),
    .sram_cen          (sram_cen),
    .sram_wen          (sram_wen),
    .sram_addr         (sram_addr),
    .sram_wdata        (sram_wdata),
    .sram_rdata        (sram_rdata)
  );

  // Behavioural SRAM: word w preloads to {C0DE, w}, word 4 to 55667788; read data one cycle after the command.
  initial begin
    for (int w = 0; w < (1 << AW); w++) mem[w] <= {16'hC0DE, 16'(w)};
    mem[4]     <= 32'h5566_7788;
    sram_rdata <= '0;
    forever begin
      @(posedge clk);
      if (!sram_cen) begin
        for (int b = 0; b < 4; b++)
          if (!sram_wen[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic ap(input int p, input logic wr, input logic [2:0] sz, input logic [31:0] a);
    hsel[p]           = 1'b1;
    htrans[p*2 +: 2]  = 2'b10;
    hwrite[p]         = wr;
    hsize[p*3 +: 3]   = sz;
    haddr[p*32 +: 32] = a;
  endtask

  task automatic idle(input int p);
    hsel[p]          = 1'b0;
    htrans[p*2 +: 2] = 2'b00;
  endtask

  task automatic wd(input int p, input logic [31:0] d);
    hwdata[p*32 +: 32] = d;
  endtask

  function automatic logic [31:0] rd(input int p);
    return hrdata[p*32 +: 32];
  endfunction

  function automatic logic [31:0] rsp(input int p);
    return {30'b0, hresp[p*2 +: 2]};
  endfunction

  initial begin
    hsel = '0; haddr = '0; htrans = '0; hwrite = '0; hsize = '0; hwdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_hready", hready, 3'b111);
    check("rst_hresp", hresp, 6'b0);
    check("rst_hrdata", hrdata[31:0] | hrdata[63:32] | hrdata[95:64], 32'h0);
    check("rst_cen", sram_cen, 1'b1);
    check("rst_wen", sram_wen, 4'hF);
    check("rst_addr", sram_addr, 14'h0);
    check("rst_wdata", sram_wdata, 32'h0);
    cyc(); cyc();
    rst_n = 1'b1;

    // Three-way read contention: fresh pointer gives order 0, 1, 2.
    cyc(); ap(0, 0, 3'd2, 32'h40); ap(1, 0, 3'd2, 32'h10); ap(2, 0, 3'd2, 32'h8); #1;
    check("cont_ap_hready", hready, 3'b111);
    cyc(); idle(0); idle(1); idle(2); #1;
    check("cont_t1_hready", hready, 3'b000);
    check("cont_t1_cen", sram_cen, 1'b0);
    check("cont_t1_addr", sram_addr, 14'h10);
    check("cont_t1_wen", sram_wen, 4'hF);
    cyc(); #1;
    check("cont_t2_hready", hready, 3'b001);
    check("cont_t2_rd0", rd(0), 32'hC0DE_0010);
    check("cont_t2_rd1_zero", rd(1), 32'h0);
    check("cont_t2_addr", sram_addr, 14'h4);
    cyc(); #1;
    check("cont_t3_hready", hready, 3'b011);
    check("cont_t3_rd1", rd(1), 32'h5566_7788);
    check("cont_t3_addr", sram_addr, 14'h2);
    // Same contention again, issued on port 2's completion cycle.
    cyc(); ap(0, 0, 3'd2, 32'h40); ap(1, 0, 3'd2, 32'h10); ap(2, 0, 3'd2, 32'h8); #1;
    check("cont_t4_hready", hready, 3'b111);
    check("cont_t4_rd2", rd(2), 32'hC0DE_0002);
    check("cont_t4_cen", sram_cen, 1'b1);
    cyc(); idle(0); idle(1); idle(2); #1;
    check("cont2_t1_addr", sram_addr, 14'h10);
    cyc(); #1;
    check("cont2_t2_addr", sram_addr, 14'h4);
    cyc(); #1;
    check("cont2_t3_addr", sram_addr, 14'h2);
    cyc(); #1;
    check("cont2_t4_rd2", rd(2), 32'hC0DE_0002);

    // Word write then pipelined word read on port 0.
    cyc(); ap(0, 1, 3'd2, 32'h40); #1;
    check("ww_ap_hready", hready[0], 1'b1);
    cyc(); idle(0); wd(0, 32'hA5A5_5A5A); #1;
    check("ww_g_hready", hready[0], 1'b0);
    check("ww_g_cen", sram_cen, 1'b0);
    check("ww_g_wen", sram_wen, 4'h0);
    check("ww_g_addr", sram_addr, 14'h10);
    check("ww_g_wdata", sram_wdata, 32'hA5A5_5A5A);
    cyc(); ap(0, 0, 3'd2, 32'h40); #1;
    check("ww_done_hready", hready[0], 1'b1);
    check("ww_done_hresp", rsp(0), 32'h0);
    check("ww_done_cen", sram_cen, 1'b1);
    cyc(); idle(0); #1;
    check("wr_g_hready", hready[0], 1'b0);
    check("wr_g_wen", sram_wen, 4'hF);
    check("wr_g_addr", sram_addr, 14'h10);
    cyc(); #1;
    check("wr_done_hready", hready[0], 1'b1);
    check("wr_done_rd0", rd(0), 32'hA5A5_5A5A);

    // Byte write to 0x13 lands in lane 3 of word 4.
    cyc(); ap(0, 1, 3'd0, 32'h13); #1;
    cyc(); idle(0); wd(0, 32'h1122_3344); #1;
    check("bw_g_wen", sram_wen, 4'b0111);
    check("bw_g_addr", sram_addr, 14'h4);
    check("bw_g_wdata", sram_wdata, 32'h1122_3344);
    cyc(); ap(0, 0, 3'd2, 32'h10); #1;
    check("bw_done_hready", hready[0], 1'b1);
    cyc(); idle(0); #1;
    check("br_g_addr", sram_addr, 14'h4);
    cyc(); #1;
    check("br_done_rd0", rd(0), 32'h1166_7788);

    // Oversized transfer on port 1; BUSY on port 0 must not be captured.
    cyc(); hsel[0] = 1'b1; htrans[1:0] = 2'b01; ap(1, 0, 3'b011, 32'h20); #1;
    check("err_ap_hready1", hready[1], 1'b1);
    check("err_ap_hresp1", rsp(1), 32'h0);
    cyc(); idle(0); idle(1); #1;
    check("err1_hready1", hready[1], 1'b0);
    check("err1_hresp1", rsp(1), 32'h1);
    check("err1_cen", sram_cen, 1'b1);
    check("busy_hready0", hready[0], 1'b1);
    cyc(); #1;
    check("err2_hready1", hready[1], 1'b1);
    check("err2_hresp1", rsp(1), 32'h1);
    check("err2_cen", sram_cen, 1'b1);
    cyc(); #1;
    check("err_end_hresp1", rsp(1), 32'h0);
    check("err_end_cen", sram_cen, 1'b1);

    // Four pipelined reads on port 2; next address phase held through each wait state.
    cyc(); ap(2, 0, 3'd2, 32'h0); #1;
    check("pipe_ap_hready", hready[2], 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k < 3) ap(2, 0, 3'd2, 32'(4 * (k + 1)));
      else idle(2);
      #1;
      check($sformatf("pipe%0d_wait_hready", k), hready[2], 1'b0);
      check($sformatf("pipe%0d_addr", k), sram_addr, 14'(k));
      cyc(); #1;
      check($sformatf("pipe%0d_done_hready", k), hready[2], 1'b1);
      check($sformatf("pipe%0d_rd2", k), rd(2), {16'hC0DE, 16'(k)});
    end

    // Reset with writes pending on ports 0 and 1.
    cyc(); ap(0, 1, 3'd2, 32'h80); ap(1, 1, 3'd2, 32'h84); #1;
    cyc(); idle(0); idle(1); wd(0, 32'hDEAD_0000); wd(1, 32'hBEEF_0000); #1;
    check("mid_pend_hready", hready, 3'b100);
    check("mid_pend_cen", sram_cen, 1'b0);
    rst_n = 1'b0; #1;
    check("mid_rst_hready", hready, 3'b111);
    check("mid_rst_cen", sram_cen, 1'b1);
    check("mid_rst_wen", sram_wen, 4'hF);
    check("mid_rst_hresp", hresp, 6'b0);
    cyc(); cyc();
    rst_n = 1'b1;

    // Neither aborted write reached the SRAM (reads via port 1 leave the pointer at 1).
    cyc(); ap(1, 0, 3'd2, 32'h80); #1;
    cyc(); idle(1); #1;
    check("post_g0_addr", sram_addr, 14'h20);
    cyc(); ap(1, 0, 3'd2, 32'h84); #1;
    check("post_rd_80", rd(1), 32'hC0DE_0020);
    cyc(); idle(1); #1;
    check("post_g1_addr", sram_addr, 14'h21);
    cyc(); #1;
    check("post_rd_84", rd(1), 32'hC0DE_0021);

    // Ports 0 and 2 contend with the pointer at 1.
    cyc(); ap(0, 0, 3'd2, 32'h8); ap(2, 0, 3'd2, 32'hC); #1;
    cyc(); idle(0); idle(2); #1;
`ifdef SMC_ARB_PRIO_EN
    check("ptr_t1_addr", sram_addr, 14'h2);
    cyc(); #1;
    check("ptr_t2_hready", hready, 3'b011);
    check("ptr_t2_rd0", rd(0), 32'hC0DE_0002);
    check("ptr_t2_addr", sram_addr, 14'h3);
    cyc(); #1;
    check("ptr_t3_rd2", rd(2), 32'hC0DE_0003);
`else
    check("ptr_t1_addr", sram_addr, 14'h3);
    cyc(); #1;
    check("ptr_t2_hready", hready, 3'b110);
    check("ptr_t2_rd2", rd(2), 32'hC0DE_0003);
    check("ptr_t2_addr", sram_addr, 14'h2);
    cyc(); #1;
    check("ptr_t3_rd0", rd(0), 32'hC0DE_0002);
`endif
    check("ptr_t3_hready", hready, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
